// File: rtl/header_parser.sv
// ---------------------------------------------------------------------------
// header_parser
//   Receives a four-word routing header (source, destination, control,
//   checksum) on a 16-bit word stream. It captures the fields, then checks
//   the checksum, hop limit and payload length. A good header produces a
//   one-cycle start pulse that launches the downstream destination-check
//   stage. Every header ends with done, which stays high until the next en.
//
// Ports
//   clock          in   single clock, all logic on posedge
//   rst            in   synchronous active-high reset
//   en             in   arms the parser for the next header (idle only)
//   data_in        in   header word
//   data_valid     in   data_in valid this cycle
//   sourceID       out  captured word 0
//   destinationID  out  captured word 1
//   pkt_type       out  ctl[15:12]
//   hop_count      out  ctl[11:8]
//   pkt_length     out  ctl[7:0]
//   start          out  one-cycle pulse: header accepted, launch next stage
//   hdr_ok         out  header accepted
//   hdr_error      out  header rejected
//   err_code       out  0 none, 1 checksum, 2 hop limit, 3 length, 4 timeout
//   done           out  parse finished; held until next en
// ---------------------------------------------------------------------------
module header_parser #(
  parameter int WORD_WIDTH = 16,
  parameter int MAX_HOPS   = 15,
  parameter int MAX_LEN    = 64,
  parameter int TIMEOUT    = 32
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  en,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic [WORD_WIDTH-1:0] sourceID,
  output logic [WORD_WIDTH-1:0] destinationID,
  output logic [3:0]            pkt_type,
  output logic [3:0]            hop_count,
  output logic [7:0]            pkt_length,
  output logic                  start,
  output logic                  hdr_ok,
  output logic                  hdr_error,
  output logic [2:0]            err_code,
  output logic                  done
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_HOLD, S_SRC, S_DST, S_CTL, S_CHK, S_FIN
  } state_t;

  state_t                state_reg, state_next;
  logic [WORD_WIDTH-1:0] src_reg, src_next;
  logic [WORD_WIDTH-1:0] dst_reg, dst_next;
  logic [3:0]            type_reg, type_next;
  logic [3:0]            hop_reg, hop_next;
  logic [7:0]            len_reg, len_next;
  logic [WORD_WIDTH-1:0] acc_reg, acc_next;
  logic [IDLE_W-1:0]     idle_reg, idle_next;
  logic                  start_reg, start_next;
  logic                  ok_reg, ok_next;
  logic                  err_reg, err_next;
  logic [2:0]            code_reg, code_next;
  logic                  done_reg, done_next;

  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    dst_next   = dst_reg;
    type_next  = type_reg;
    hop_next   = hop_reg;
    len_next   = len_reg;
    acc_next   = acc_reg;
    idle_next  = idle_reg;
    start_next = 1'b0;      // start only ever lives for a single cycle
    ok_next    = ok_reg;
    err_next   = err_reg;
    code_next  = code_reg;
    done_next  = done_reg;

    case (state_reg)
      S_HOLD: begin
        if (en) begin
          src_next   = '0;
          dst_next   = '0;
          type_next  = '0;
          hop_next   = '0;
          len_next   = '0;
          acc_next   = '0;
          idle_next  = '0;
          ok_next    = 1'b0;
          err_next   = 1'b0;
          code_next  = 3'd0;
          done_next  = 1'b0;
          state_next = S_SRC;
        end
      end

      // No timeout while waiting for the first word of a packet.
      S_SRC: begin
        if (data_valid) begin
          src_next   = data_in;
          acc_next   = data_in;
          idle_next  = '0;
          state_next = S_DST;
        end
      end

      S_DST, S_CTL, S_CHK: begin
        if (data_valid) begin
          // An accept on the last allowed idle cycle beats the timeout.
          idle_next = '0;
          acc_next  = acc_reg ^ data_in;
          if (state_reg == S_DST) begin
            dst_next   = data_in;
            state_next = S_CTL;
          end else if (state_reg == S_CTL) begin
            type_next  = data_in[15:12];
            hop_next   = data_in[11:8];
            len_next   = data_in[7:0];
            state_next = S_CHK;
          end else begin
            // Checks in priority order: checksum, hop limit, length.
            err_next = 1'b1;
            if (data_in != acc_reg) begin
              code_next = 3'd1;
            end else if (int'(hop_reg) >= MAX_HOPS) begin
              code_next = 3'd2;
            end else if (len_reg == 8'd0 || int'(len_reg) > MAX_LEN) begin
              code_next = 3'd3;
            end else begin
              err_next   = 1'b0;
              ok_next    = 1'b1;
              start_next = 1'b1;
            end
            state_next = S_FIN;
          end
        end else if (idle_reg == IDLE_LAST) begin
          err_next   = 1'b1;
          code_next  = 3'd4;
          idle_next  = '0;
          state_next = S_FIN;
        end else begin
          idle_next = idle_reg + 1'b1;
        end
      end

      S_FIN: begin
        done_next  = 1'b1;
        state_next = S_HOLD;
      end

      default: state_next = S_HOLD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_reg <= S_HOLD;
      src_reg   <= '0;
      dst_reg   <= '0;
      type_reg  <= '0;
      hop_reg   <= '0;
      len_reg   <= '0;
      acc_reg   <= '0;
      idle_reg  <= '0;
      start_reg <= 1'b0;
      ok_reg    <= 1'b0;
      err_reg   <= 1'b0;
      code_reg  <= 3'd0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      type_reg  <= type_next;
      hop_reg   <= hop_next;
      len_reg   <= len_next;
      acc_reg   <= acc_next;
      idle_reg  <= idle_next;
      start_reg <= start_next;
      ok_reg    <= ok_next;
      err_reg   <= err_next;
      code_reg  <= code_next;
      done_reg  <= done_next;
    end
  end

  assign sourceID      = src_reg;
  assign destinationID = dst_reg;
  assign pkt_type      = type_reg;
  assign hop_count     = hop_reg;
  assign pkt_length    = len_reg;
  assign start         = start_reg;
  assign hdr_ok        = ok_reg;
  assign hdr_error     = err_reg;
  assign err_code      = code_reg;
  assign done          = done_reg;

endmodule

// File: tb/tb_header_parser.sv
// ---------------------------------------------------------------------------
// tb_header_parser
//   Directed and randomized header streams for header_parser. Expected results
//   come from a packet-level model: checksum/hop/length rules on the words,
//   plus gap lengths between words for the timeout.
// ---------------------------------------------------------------------------
module tb_header_parser;

  localparam int MAX_HOPS = 15;
  localparam int MAX_LEN  = 64;
  localparam int TIMEOUT  = 32;

  logic        clock = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] data_in;
  logic        data_valid;
  logic [15:0] sourceID;
  logic [15:0] destinationID;
  logic [3:0]  pkt_type;
  logic [3:0]  hop_count;
  logic [7:0]  pkt_length;
  logic        start;
  logic        hdr_ok;
  logic        hdr_error;
  logic [2:0]  err_code;
  logic        done;

  int checks   = 0;
  int failures = 0;

  header_parser dut (
    .clock         (clock),
    .rst           (rst),
    .en            (en),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .sourceID      (sourceID),
    .destinationID (destinationID),
    .pkt_type      (pkt_type),
    .hop_count     (hop_count),
    .pkt_length    (pkt_length),
    .start         (start),
    .hdr_ok        (hdr_ok),
    .hdr_error     (hdr_error),
    .err_code      (err_code),
    .done          (done)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after each posedge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference rules for a fully received header.
  function automatic int model_code(input logic [15:0] a, input logic [15:0] b,
                                    input logic [15:0] c, input logic [15:0] d);
    int hops;
    int len;
    hops = int'(c[11:8]);
    len  = int'(c[7:0]);
    if (d !== (a ^ b ^ c)) return 1;
    if (hops >= MAX_HOPS) return 2;
    if (len == 0 || len > MAX_LEN) return 3;
    return 0;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_src"},   32'(sourceID), 32'h0);
    check({tag, "_dst"},   32'(destinationID), 32'h0);
    check({tag, "_ctl"},   32'({pkt_type, hop_count, pkt_length}), 32'h0);
    check({tag, "_flags"}, 32'({start, hdr_ok, hdr_error, err_code, done}), 32'h0);
  endtask

  // Arms the parser, sends the four words with g[i] idle cycles before word i,
  // and checks the result edge and the done edge. en_mid re-asserts en
  // together with word 1, which the parser must ignore.
  task automatic run_packet(input string tag,
                            input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3,
                            input int g0, input int g1, input int g2, input int g3,
                            input bit en_mid);
    logic [15:0] w[4];
    int          g[4];
    int          n_acc;
    int          code;
    bit          timed_out;
    logic [15:0] exp_src, exp_dst, exp_ctl;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;

    data_valid = 1'b0;
    en = 1'b1;
    tick();
    en = 1'b0;
    check({tag, "_armed_done"}, 32'(done), 32'h0);

    timed_out = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 4 && !timed_out; i++) begin
      for (int k = 0; k < g[i] && !timed_out; k++) begin
        data_valid = 1'b0;
        data_in = 16'($urandom);
        tick();
        if (i > 0 && k + 1 == TIMEOUT) timed_out = 1'b1;
      end
      if (!timed_out) begin
        data_valid = 1'b1;
        data_in = w[i];
        if (i == 1) en = en_mid;
        tick();
        en = 1'b0;
        data_valid = 1'b0;
        n_acc++;
      end
    end

    code    = timed_out ? 4 : model_code(w0, w1, w2, w3);
    exp_src = (n_acc >= 1) ? w0 : 16'h0;
    exp_dst = (n_acc >= 2) ? w1 : 16'h0;
    exp_ctl = (n_acc >= 3) ? w2 : 16'h0;

    check({tag, "_start"},    32'(start), 32'(code == 0));
    check({tag, "_hdr_ok"},   32'(hdr_ok), 32'(code == 0));
    check({tag, "_hdr_err"},  32'(hdr_error), 32'(code != 0));
    check({tag, "_err_code"}, 32'(err_code), 32'(code));
    check({tag, "_done_early"}, 32'(done), 32'h0);
    check({tag, "_src"},      32'(sourceID), 32'(exp_src));
    check({tag, "_dst"},      32'(destinationID), 32'(exp_dst));
    check({tag, "_fields"},   32'({pkt_type, hop_count, pkt_length}), 32'(exp_ctl));

    // A word offered during the finishing cycle must be dropped.
    data_valid = 1'b1;
    data_in = 16'($urandom);
    tick();
    data_valid = 1'b0;
    check({tag, "_start_off"}, 32'(start), 32'h0);
    check({tag, "_done"},      32'(done), 32'h1);
    check({tag, "_src_kept"},  32'(sourceID), 32'(exp_src));
    $display("pkt %s words=%h,%h,%h,%h gaps=%0d,%0d,%0d,%0d code=%0d", tag,
             w0, w1, w2, w3, g0, g1, g2, g3, code);
  endtask

  initial begin
    logic [15:0] r0, r1, r2, r3;
    logic [3:0]  rhop;
    logic [7:0]  rlen;
    int          rg[4];
    int          sel;

    rst = 1'b1; en = 1'b0; data_valid = 1'b0; data_in = 16'h0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("reset_idle");

    // T1 good header, back-to-back
    run_packet("t1_good", 16'h0003, 16'h0007, 16'h1240, 16'h1244, 0, 0, 0, 0, 1'b0);
    check("t1_type", 32'(pkt_type), 32'h1);
    check("t1_hop",  32'(hop_count), 32'h2);
    check("t1_len",  32'(pkt_length), 32'd64);
    // T2 checksum error
    run_packet("t2_cksum", 16'h0003, 16'h0007, 16'h1240, 16'h1245, 0, 0, 0, 0, 1'b0);
    // T3 hop limit
    run_packet("t3_hop", 16'h0003, 16'h0007, 16'h1F10, 16'h0003 ^ 16'h0007 ^ 16'h1F10,
               0, 0, 0, 0, 1'b0);
    // Length boundaries: 0 and 65 rejected, 1 accepted
    run_packet("len0", 16'h0003, 16'h0007, 16'h1200, 16'h0003 ^ 16'h0007 ^ 16'h1200,
               0, 0, 0, 0, 1'b0);
    run_packet("len65", 16'h0003, 16'h0007, 16'h1241, 16'h0003 ^ 16'h0007 ^ 16'h1241,
               0, 0, 0, 0, 1'b0);
    run_packet("len1", 16'h0003, 16'h0007, 16'h1E01, 16'h0003 ^ 16'h0007 ^ 16'h1E01,
               0, 0, 0, 0, 1'b0);
    // T4 timeout after 32 idle cycles; 31 idle cycles then a word is accepted
    run_packet("t4_timeout", 16'h0003, 16'h0007, 16'h1240, 16'h1244, 0, 0, 32, 0, 1'b0);
    run_packet("t4_edge", 16'h0003, 16'h0007, 16'h1240, 16'h1244, 0, 31, 31, 31, 1'b0);
    run_packet("src_wait", 16'h0003, 16'h0007, 16'h1240, 16'h1244, 60, 0, 0, 0, 1'b0);

    // T5 reset mid-packet
    en = 1'b1;
    tick();
    en = 1'b0;
    data_valid = 1'b1; data_in = 16'h0003; tick();
    data_in = 16'h0007; tick();
    data_valid = 1'b0;
    rst = 1'b1;
    tick();
    check_all_zero("t5_rst");
    rst = 1'b0;
    tick();
    check_all_zero("t5_after");
    run_packet("t5_good", 16'h0003, 16'h0007, 16'h1240, 16'h1244, 0, 0, 0, 0, 1'b0);

    // T6 en mid-packet ignored; words in S_HOLD dropped; back-to-back packets
    run_packet("t6_a", 16'h00A1, 16'h00B2, 16'h3510, 16'h00A1 ^ 16'h00B2 ^ 16'h3510,
               0, 0, 0, 0, 1'b1);
    data_valid = 1'b1; data_in = 16'hDEAD; tick();
    data_in = 16'hBEEF; tick();
    data_valid = 1'b0;
    check("t6_hold_done", 32'(done), 32'h1);
    check("t6_hold_src",  32'(sourceID), 32'h00A1);
    check("t6_hold_dst",  32'(destinationID), 32'h00B2);
    run_packet("t6_b", 16'h0C01, 16'h0D02, 16'h7E20, 16'h0C01 ^ 16'h0D02 ^ 16'h7E20,
               0, 0, 0, 0, 1'b0);

    // Randomized packets against the model
    for (int p = 0; p < 40; p++) begin
      r0   = 16'($urandom);
      r1   = 16'($urandom);
      rhop = 4'($urandom_range(0, 15));
      sel  = int'($urandom_range(0, 9));
      if (sel == 0)      rlen = 8'd0;
      else if (sel == 1) rlen = 8'($urandom_range(65, 255));
      else if (sel == 2) rlen = 8'd64;
      else               rlen = 8'($urandom_range(1, 63));
      r2 = {4'($urandom), rhop, rlen};
      r3 = r0 ^ r1 ^ r2;
      if ($urandom_range(0, 3) == 0) r3 = r3 ^ (16'h1 << $urandom_range(0, 15));
      rg[0] = int'($urandom_range(0, 40));
      for (int i = 1; i < 4; i++) begin
        sel = int'($urandom_range(0, 11));
        if (sel == 0)      rg[i] = 31;
        else if (sel == 1) rg[i] = 32;
        else if (sel == 2) rg[i] = int'($urandom_range(33, 40));
        else               rg[i] = int'($urandom_range(0, 4));
      end
      run_packet($sformatf("rnd%0d", p), r0, r1, r2, r3, rg[0], rg[1], rg[2], rg[3],
                 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
